// File: rtl/dac_serial_pkg.sv
// rtl/dac_serial_pkg.sv - shared state enum, frame constants and helpers for the serial DAC updater
// Contents: dac_state_t, FRAME_BITS, DATA_BITS, MAX_CH, dac_frame(), rr_pick()
// Macro DAC_LDAC_EN adds the ST_LDAC state.
package dac_serial_pkg;

    localparam int FRAME_BITS = 24;
    localparam int DATA_BITS  = 16;
    localparam int MAX_CH     = 16;

`ifdef DAC_LDAC_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD, ST_SHIFT_HI, ST_SHIFT_LO, ST_TAIL, ST_GAP, ST_LDAC
    } dac_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD, ST_SHIFT_HI, ST_SHIFT_LO, ST_TAIL, ST_GAP
    } dac_state_t;
`endif

    function automatic logic [FRAME_BITS-1:0] dac_frame(
        input logic [3:0]           cmd_nibble,
        input logic [3:0]           ch,
        input logic [DATA_BITS-1:0] data
    );
        return {cmd_nibble, ch, data};
    endfunction

    // Lowest pending channel at or above ptr, wrapping past num_ch-1 back to 0.
    // ptr < num_ch always holds, so ptr + i stays below 2*num_ch and one
    // subtraction is enough to wrap.
    function automatic logic [3:0] rr_pick(
        input logic [MAX_CH-1:0] pend,
        input logic [3:0]        ptr,
        input int                num_ch
    );
        logic [3:0] pick;
        logic       found;
        logic [4:0] idx;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < MAX_CH; i++) begin
            idx = {1'b0, ptr} + 5'(i);
            if (idx >= 5'(num_ch)) idx = idx - 5'(num_ch);
            if (i < num_ch && !found && pend[idx[3:0]]) begin
                pick  = idx[3:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/dac_tick_gen.sv
// rtl/dac_tick_gen.sv - free-running clock-enable generator, one tick every CLK_DIV cycles
// Ports: clk_100M, rst_n (async, active low) in; tick out (single-cycle pulse).
module dac_tick_gen #(
    parameter int CLK_DIV = 25
) (
    input  logic clk_100M,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt_q;

    assign tick = (cnt_q == CW'(CLK_DIV - 1));

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n)    cnt_q <= '0;
        else if (tick) cnt_q <= '0;
        else           cnt_q <= cnt_q + 1'b1;
    end

endmodule

// File: rtl/dac_serial_multi.sv
// rtl/dac_serial_multi.sv - multi-channel change-driven serial DAC updater (SYNC/SCLK/SDIN)
// Ports: clk_100M, rst_n (async, active low), value[NUM_CH*16], force_update in;
//        busy, sclk, sdata, sync out; ldac_n out only when DAC_LDAC_EN is defined.
// Macro DAC_LDAC_EN adds the LDAC state, the LDAC_WIDTH parameter and the ldac_n port.
module dac_serial_multi
    import dac_serial_pkg::*;
#(
    parameter int         NUM_CH     = 2,
    parameter int         CLK_DIV    = 25,
    parameter logic [3:0] CMD_NIBBLE = 4'h1,
    parameter int         SYNC_GAP   = 2
`ifdef DAC_LDAC_EN
    , parameter int       LDAC_WIDTH = 2
`endif
) (
    input  logic                        clk_100M,
    input  logic                        rst_n,
    input  logic [NUM_CH*DATA_BITS-1:0] value,
    input  logic                        force_update,
    output logic                        busy,
    output logic                        sclk,
    output logic                        sdata,
    output logic                        sync
`ifdef DAC_LDAC_EN
    , output logic                      ldac_n
`endif
);

    logic tick;

    dac_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk_100M (clk_100M),
        .rst_n    (rst_n),
        .tick     (tick)
    );

    dac_state_t state_q, state_d;
    logic [4:0] bit_q, bit_d;
    logic [3:0] ch_q, ch_d;
    logic [3:0] rr_q, rr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [DATA_BITS-1:0] tx_q, tx_d;
    logic sclk_q, sclk_d, sync_q, sync_d, sdata_q, sdata_d;
`ifdef DAC_LDAC_EN
    logic ldac_q, ldac_d;
    assign ldac_n = ldac_q;
`endif
    logic tail_fire;

    logic [NUM_CH-1:0]    pending, pend_d;
    logic [MAX_CH-1:0]    pend_ext;
    logic [DATA_BITS-1:0] last_written [NUM_CH];
    logic [DATA_BITS-1:0] lw_d [NUM_CH];
    logic [DATA_BITS-1:0] sel_val;
    logic [FRAME_BITS-1:0] frame;

    assign frame = dac_frame(CMD_NIBBLE, ch_q, tx_q);
    assign busy  = (|pending) || (state_q != ST_IDLE);
    assign sclk  = sclk_q;
    assign sync  = sync_q;
    assign sdata = sdata_q;

    always_comb begin
        pend_ext = '0;
        pend_ext[NUM_CH-1:0] = pending;
        sel_val = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (ch_q == 4'(c)) sel_val = value[c*DATA_BITS +: DATA_BITS];
    end

    // The dirty test compares against last_written as it will be after this
    // edge; otherwise the TAIL cycle would see the stale word and re-arm a
    // channel that was just written with its current value.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            lw_d[c]   = last_written[c];
            pend_d[c] = pending[c];
            if (tail_fire && ch_q == 4'(c)) begin
                lw_d[c]   = tx_q;
                pend_d[c] = 1'b0;
            end
            if (force_update || value[c*DATA_BITS +: DATA_BITS] != lw_d[c])
                pend_d[c] = 1'b1;
        end
    end

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '1;
            for (int c = 0; c < NUM_CH; c++) last_written[c] <= '0;
        end else begin
            pending <= pend_d;
            for (int c = 0; c < NUM_CH; c++) last_written[c] <= lw_d[c];
        end
    end

    // IDLE selects on any cycle, not only on a tick, so a frame occupies
    // exactly LOAD + 48 shift + TAIL + SYNC_GAP ticks back to back.
    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        ch_d      = ch_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        tx_d      = tx_q;
        sclk_d    = sclk_q;
        sync_d    = sync_q;
        sdata_d   = sdata_q;
        tail_fire = 1'b0;
`ifdef DAC_LDAC_EN
        ldac_d    = ldac_q;
`endif
        case (state_q)
            ST_IDLE: if (|pending) begin
                ch_d    = rr_pick(pend_ext, rr_q, NUM_CH);
                state_d = ST_LOAD;
            end
            ST_LOAD: if (tick) begin
                tx_d    = sel_val;
                sync_d  = 1'b0;
                sclk_d  = 1'b1;
                bit_d   = 5'(FRAME_BITS - 1);
                state_d = ST_SHIFT_HI;
            end
            ST_SHIFT_HI: if (tick) begin
                sdata_d = frame[bit_q];
                sclk_d  = 1'b1;
                state_d = ST_SHIFT_LO;
            end
            ST_SHIFT_LO: if (tick) begin
                sclk_d = 1'b0;
                if (bit_q == 5'd0) state_d = ST_TAIL;
                else begin
                    bit_d   = bit_q - 5'd1;
                    state_d = ST_SHIFT_HI;
                end
            end
            ST_TAIL: if (tick) begin
                sclk_d    = 1'b1;
                sync_d    = 1'b1;
                sdata_d   = 1'b0;
                tail_fire = 1'b1;
                rr_d      = (ch_q == 4'(NUM_CH - 1)) ? 4'd0 : ch_q + 4'd1;
                cnt_d     = '0;
                state_d   = ST_GAP;
            end
            ST_GAP: if (tick) begin
                if (cnt_q == 8'(SYNC_GAP - 1)) begin
                    cnt_d = '0;
`ifdef DAC_LDAC_EN
                    if (!(|pending)) begin
                        ldac_d  = 1'b0;
                        state_d = ST_LDAC;
                    end else begin
                        state_d = ST_IDLE;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
`ifdef DAC_LDAC_EN
            ST_LDAC: if (tick) begin
                if (cnt_q == 8'(LDAC_WIDTH - 1)) begin
                    ldac_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            bit_q   <= '0;
            ch_q    <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            tx_q    <= '0;
            sclk_q  <= 1'b1;
            sync_q  <= 1'b1;
            sdata_q <= 1'b0;
`ifdef DAC_LDAC_EN
            ldac_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            ch_q    <= ch_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            sclk_q  <= sclk_d;
            sync_q  <= sync_d;
            sdata_q <= sdata_d;
`ifdef DAC_LDAC_EN
            ldac_q  <= ldac_d;
`endif
        end
    end

endmodule
